// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and the round-robin search used by the memory port arbiter.
package mem_arb_pkg;

    localparam int MAX_NREQ = 8;
    localparam int IDX_W    = $clog2(MAX_NREQ);

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic found;
        idx_t idx;
    } pick_t;

    // Search ascending from prio, wrapping at nreq-1 -> 0; first valid index wins.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                      input idx_t prio,
                                      input int nreq);
        pick_t p;
        int    j;
        p = '0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            j = int'(prio) + k;
            if (j >= nreq) j = j - nreq;
            if (k < nreq && !p.found && valid[j[IDX_W-1:0]]) begin
                p.found = 1'b1;
                p.idx   = idx_t'(j);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and RAM-side bundles of the memory port arbiter.
interface mem_arb_req_if #(
    parameter int WIDTH = 8,
    parameter int DATA  = 32,
    parameter int NREQ  = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_we;
    logic [NREQ*WIDTH-1:0] req_addr;
    logic [NREQ*DATA-1:0]  req_wdata;
    logic [NREQ-1:0]       rsp_valid;
    logic [DATA-1:0]       rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

interface mem_arb_mem_if #(
    parameter int WIDTH = 8,
    parameter int DATA  = 32
);
    logic             mem_w;
    logic [WIDTH-1:0] mem_addr;
    logic [DATA-1:0]  mem_wdata;
    logic [DATA-1:0]  mem_rdata;

    modport master (
        output mem_w, mem_addr, mem_wdata,
        input  mem_rdata
    );
    modport slave (
        input  mem_w, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter_rr.sv
// Round-robin grant generator; owns the priority pointer.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] valid,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output idx_t            grant_idx
);

    idx_t  prio;
    pick_t pick;

    assign pick      = rr_pick(MAX_NREQ'(valid), prio, NREQ);
    assign grant_idx = pick.idx;

    always_comb begin
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = pick.found && (pick.idx == idx_t'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio <= '0;
        end else if (advance) begin
            prio <= (grant_idx == idx_t'(NREQ - 1)) ? '0 : grant_idx + idx_t'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM among NREQ requesters, round-robin,
// and routes each read response back to the requester that issued it.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DATA  = 32,
    parameter int NREQ  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arb_req_if.slave  req,
    mem_arb_mem_if.master mem
);

    logic [NREQ-1:0] grant;
    idx_t            grant_idx;
    logic            rd_accept;
    logic            rd_pend;
    idx_t            rd_owner;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (req.req_valid),
        .advance   (|req.req_ready),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req.req_ready = grant & {NREQ{rst_n}};
    assign rd_accept     = |(req.req_ready & ~req.req_we);

    always_comb begin
        mem.mem_w     = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req.req_ready[i]) begin
                mem.mem_w     = req.req_we[i];
                mem.mem_addr  = req.req_addr[i*WIDTH +: WIDTH];
                mem.mem_wdata = req.req_wdata[i*DATA +: DATA];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= '0;
        end else begin
            rd_pend <= rd_accept;
            if (rd_accept) rd_owner <= grant_idx;
        end
    end

    // A response pending when reset asserts is suppressed immediately, not a cycle late.
    always_comb begin
        req.rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            req.rsp_valid[i] = rd_pend && rst_n && (rd_owner == idx_t'(i));
        end
    end

    assign req.rsp_rdata = mem.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a 2-requester arbiter with a behavioural RAM, plus a 3-requester instance for wrap checks.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_arb_req_if #(.WIDTH(8), .DATA(32), .NREQ(2)) ra ();
    mem_arb_mem_if #(.WIDTH(8), .DATA(32))           ma ();
    mem_arb_req_if #(.WIDTH(8), .DATA(32), .NREQ(3)) rb ();
    mem_arb_mem_if #(.WIDTH(8), .DATA(32))           mb ();

    mem_port_arbiter #(.WIDTH(8), .DATA(32), .NREQ(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (ra.slave),
        .mem   (ma.master)
    );

    mem_port_arbiter #(.WIDTH(8), .DATA(32), .NREQ(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rb.slave),
        .mem   (mb.master)
    );

    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (ma.mem_w) ram[ma.mem_addr] <= ma.mem_wdata;
        ma.mem_rdata <= ram[ma.mem_addr];
    end
    assign mb.mem_rdata = 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drv_a(input logic [1:0] v, input logic [1:0] we,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        ra.req_valid = v;
        ra.req_we    = we;
        ra.req_addr  = {a1, a0};
        ra.req_wdata = {d1, d0};
    endtask

    task automatic drv_b(input logic [2:0] v, input logic [7:0] a0,
                         input logic [7:0] a1, input logic [7:0] a2);
        rb.req_valid = v;
        rb.req_we    = 3'b000;
        rb.req_addr  = {a2, a1, a0};
        rb.req_wdata = '0;
    endtask

    // Inputs change 1 time unit after posedge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drv_a(2'b11, 2'b11, 8'h05, 8'h06, 32'h1, 32'h2);
        drv_b(3'b000, 8'h0, 8'h0, 8'h0);
        rst_n = 1'b0;
        #1;

        // Reset with every requester asking
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            chk("rst_ready", ra.req_ready, 2'b00);
            chk("rst_mem_w", ma.mem_w, 1'b0);
            chk("rst_rsp",   ra.rsp_valid, 2'b00);
        end

        tick();
        rst_n = 1'b1;
        drv_a(2'b01, 2'b01, 8'h10, 8'h00, 32'hDEADBEEF, 32'h0);
        #1;
        chk("wr_ready", ra.req_ready, 2'b01);
        chk("wr_mem_w", ma.mem_w, 1'b1);
        chk("wr_addr",  ma.mem_addr, 8'h10);
        chk("wr_wdata", ma.mem_wdata, 32'hDEADBEEF);

        tick();
        drv_a(2'b01, 2'b00, 8'h10, 8'h00, 32'h0, 32'h0);
        #1;
        chk("rd_ready", ra.req_ready, 2'b01);
        chk("rd_mem_w", ma.mem_w, 1'b0);

        tick();
        drv_a(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        #1;
        chk("rd_rsp",   ra.rsp_valid, 2'b01);
        chk("rd_data",  ra.rsp_rdata, 32'hDEADBEEF);
        chk("idle_rdy", ra.req_ready, 2'b00);
        chk("idle_adr", ma.mem_addr, 8'h00);

        // Preload through requester 0
        for (int k = 0; k < 6; k++) begin
            logic [7:0]  pa;
            logic [31:0] pd;
            pa = (k == 0) ? 8'h01 : (k == 1) ? 8'h02 : 8'(8'h1E + k);
            pd = (k == 0) ? 32'h11 : (k == 1) ? 32'h22 : 32'hA0A0_0000 + 32'(8'h1E + k);
            tick();
            drv_a(2'b01, 2'b01, pa, 8'h00, pd, 32'h0);
            #1;
            chk("pre_ready", ra.req_ready, 2'b01);
        end

        tick();
        drv_a(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Both requesters hold reads: grants alternate starting at 0
        drv_a(2'b11, 2'b00, 8'h01, 8'h02, 32'h0, 32'h0);
        #1;
        chk("alt_g0", ra.req_ready, 2'b01);
        chk("alt_r0", ra.rsp_valid, 2'b00);
        tick();
        #1;
        chk("alt_g1", ra.req_ready, 2'b10);
        chk("alt_r1", ra.rsp_valid, 2'b01);
        chk("alt_d1", ra.rsp_rdata, 32'h11);
        tick();
        #1;
        chk("alt_g2", ra.req_ready, 2'b01);
        chk("alt_r2", ra.rsp_valid, 2'b10);
        chk("alt_d2", ra.rsp_rdata, 32'h22);
        tick();
        #1;
        chk("alt_g3", ra.req_ready, 2'b10);
        chk("alt_r3", ra.rsp_valid, 2'b01);
        chk("alt_d3", ra.rsp_rdata, 32'h11);
        tick();
        drv_a(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        #1;
        chk("alt_r4", ra.rsp_valid, 2'b10);
        chk("alt_d4", ra.rsp_rdata, 32'h22);

        // Requester 1 streams four reads
        for (int k = 0; k < 4; k++) begin
            tick();
            drv_a(2'b10, 2'b00, 8'h00, 8'(8'h20 + k), 32'h0, 32'h0);
            #1;
            chk("str_ready", ra.req_ready, 2'b10);
            chk("str_addr",  ma.mem_addr, 8'(8'h20 + k));
            if (k > 0) begin
                chk("str_rsp",  ra.rsp_valid, 2'b10);
                chk("str_data", ra.rsp_rdata, 32'hA0A0_0020 + 32'(k - 1));
            end
        end
        tick();
        drv_a(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        #1;
        chk("str_rsp3",  ra.rsp_valid, 2'b10);
        chk("str_data3", ra.rsp_rdata, 32'hA0A0_0023);
        tick();
        #1;
        chk("str_end", ra.rsp_valid, 2'b00);

        // Three requesters: move prio to 2 via req1, then 2 and 0 compete
        drv_b(3'b010, 8'h30, 8'h31, 8'h32);
        #1;
        chk("b_g1", rb.req_ready, 3'b010);
        tick();
        drv_b(3'b101, 8'h30, 8'h31, 8'h32);
        #1;
        chk("b_g2",   rb.req_ready, 3'b100);
        chk("b_adr2", mb.mem_addr, 8'h32);
        chk("b_rsp1", rb.rsp_valid, 3'b010);
        tick();
        #1;
        chk("b_wrap", rb.req_ready, 3'b001);
        chk("b_rsp2", rb.rsp_valid, 3'b100);
        tick();
        drv_b(3'b010, 8'h30, 8'h31, 8'h32);
        #1;
        chk("b_solo", rb.req_ready, 3'b010);
        chk("b_rsp0", rb.rsp_valid, 3'b001);
        tick();
        drv_b(3'b000, 8'h0, 8'h0, 8'h0);

        // Read accepted, then reset the next cycle: the response is dropped
        drv_a(2'b01, 2'b00, 8'h10, 8'h00, 32'h0, 32'h0);
        #1;
        chk("drop_acc", ra.req_ready, 2'b01);
        tick();
        rst_n = 1'b0;
        drv_a(2'b11, 2'b00, 8'h01, 8'h02, 32'h0, 32'h0);
        #1;
        chk("drop_rsp", ra.rsp_valid, 2'b00);
        chk("drop_rdy", ra.req_ready, 2'b00);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rsp", ra.rsp_valid, 2'b00);
        chk("post_g0",  ra.req_ready, 2'b01);
        tick();
        #1;
        chk("post_g1",  ra.req_ready, 2'b10);
        chk("post_r0",  ra.rsp_valid, 2'b01);
        chk("post_d0",  ra.rsp_rdata, 32'h11);
        tick();
        drv_a(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
